piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter; the serialising end of our serial shift-register links.

---
 rtl/piso_serializer_if.sv | 7 +
 rtl/piso_serializer.sv | 57 +++++
 tb/tb_piso_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel word handshake in, framed serial bit stream out
interface piso_serializer_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] din;
    logic din_valid, din_ready, sout, sout_valid, sout_first, sout_last, busy;
    modport master (output din, din_valid, input din_ready, sout, sout_valid, sout_first, sout_last, busy);
    modport slave (input din, din_valid, output din_ready, sout, sout_valid, sout_first, sout_last, busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with first/last framing strobes
module piso_serializer #(
    parameter int WIDTH = 4,
    parameter bit MSB_FIRST = 1
) (
    input logic clk,
    input logic rst,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [WIDTH-1:0] sr, nxt;
    logic [CW-1:0] cnt;
    logic accept;
    always_comb begin
        nxt = MSB_FIRST ? sr << 1 : sr >> 1;
        bus.din_ready = state == IDLE || (state == SHIFT && cnt == LAST);
        accept = bus.din_valid && bus.din_ready;
    end
    assign bus.busy = state == SHIFT;
    // accept wins over end-of-word so back-to-back words stream without a gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            bus.sout <= 1'b0;
            bus.sout_valid <= 1'b0;
            bus.sout_first <= 1'b0;
            bus.sout_last <= 1'b0;
        end else if (accept) begin
            state <= SHIFT;
            sr <= bus.din;
            cnt <= '0;
            bus.sout <= MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
            bus.sout_valid <= 1'b1;
            bus.sout_first <= 1'b1;
            bus.sout_last <= 1'b0;
        end else if (state == SHIFT && cnt != LAST) begin
            sr <= nxt;
            cnt <= cnt + 1'b1;
            bus.sout <= MSB_FIRST ? nxt[WIDTH-1] : nxt[0];
            bus.sout_valid <= 1'b1;
            bus.sout_first <= 1'b0;
            bus.sout_last <= cnt + 1'b1 == LAST;
        end else begin
            state <= IDLE;
            cnt <= '0;
            bus.sout <= 1'b0;
            bus.sout_valid <= 1'b0;
            bus.sout_first <= 1'b0;
            bus.sout_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first and LSB-first instances driven in lockstep, checked against directed and queue-model expectations
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] din = '0;
    logic din_valid = 1'b0;
    int nchk = 0;
    int nerr = 0;
    logic [3:0] ea, eb;
    logic [3:0] qa[$], qb[$];

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) ia ();
    piso_serializer_if #(.WIDTH(4)) ib ();
    assign ia.din = din;
    assign ia.din_valid = din_valid;
    assign ib.din = din;
    assign ib.din_valid = din_valid;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    function automatic logic [3:0] oa();
        return {ia.sout, ia.sout_valid, ia.sout_first, ia.sout_last};
    endfunction

    function automatic logic [3:0] ob();
        return {ib.sout, ib.sout_valid, ib.sout_first, ib.sout_last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            nchk++;
            if ({oa(), ia.din_ready, ia.busy} !== 6'b000010) begin
                nerr++;
                $display("FAIL reset_idle_a cycle %0d: got %b want 000010", i, {oa(), ia.din_ready, ia.busy});
            end
            nchk++;
            if ({ob(), ib.din_ready, ib.busy} !== 6'b000010) begin
                nerr++;
                $display("FAIL reset_idle_b cycle %0d: got %b want 000010", i, {ob(), ib.din_ready, ib.busy});
            end
        end
    endtask

    task automatic test_single_word();
        logic [3:0] w = 4'b1011;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            if (k <= 4) begin
                ea = {w[4-k], 1'b1, k == 1, k == 4};
                eb = {w[k-1], 1'b1, k == 1, k == 4};
            end else begin
                ea = '0;
                eb = '0;
            end
            nchk++;
            if (oa() !== ea) begin
                nerr++;
                $display("FAIL single_msb +%0d: got %b want %b", k, oa(), ea);
            end
            nchk++;
            if (ob() !== eb) begin
                nerr++;
                $display("FAIL single_lsb +%0d: got %b want %b", k, ob(), eb);
            end
            nchk++;
            if (ia.busy !== (k <= 4)) begin
                nerr++;
                $display("FAIL single_busy +%0d: got %b want %b", k, ia.busy, k <= 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w1 = 4'b1011;
        logic [3:0] w2 = 4'b0110;
        logic [3:0] w;
        int j;
        din = w1;
        din_valid = 1'b1;
        tick();
        din = w2;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            if (k == 5) din_valid = 1'b0;
            w = k <= 4 ? w1 : w2;
            j = (k - 1) % 4;
            if (k <= 8) begin
                ea = {w[3-j], 1'b1, j == 0, j == 3};
                eb = {w[j], 1'b1, j == 0, j == 3};
            end else begin
                ea = '0;
                eb = '0;
            end
            nchk++;
            if (oa() !== ea) begin
                nerr++;
                $display("FAIL b2b_msb +%0d: got %b want %b", k, oa(), ea);
            end
            nchk++;
            if (ob() !== eb) begin
                nerr++;
                $display("FAIL b2b_lsb +%0d: got %b want %b", k, ob(), eb);
            end
            nchk++;
            if (ia.din_ready !== (k == 4 || k >= 8)) begin
                nerr++;
                $display("FAIL b2b_ready +%0d: got %b want %b", k, ia.din_ready, k == 4 || k >= 8);
            end
        end
    endtask

    task automatic test_ignore();
        logic [3:0] w = 4'b1011;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            if (k == 1) begin
                din = 4'hF;
                din_valid = 1'b1;
            end
            if (k == 3) din_valid = 1'b0;
            ea = k <= 4 ? {w[(4-k)&3], 1'b1, k == 1, k == 4} : 4'b0000;
            nchk++;
            if (oa() !== ea) begin
                nerr++;
                $display("FAIL ignore_bits +%0d: got %b want %b", k, oa(), ea);
            end
            if (k <= 2) begin
                nchk++;
                if (ia.din_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL ignore_ready +%0d: got %b want 0", k, ia.din_ready);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] w = 4'b0001;
        din = 4'b1011;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nchk++;
        if ({oa(), ia.din_ready, ia.busy} !== 6'b000010) begin
            nerr++;
            $display("FAIL rst_mid_a: got %b want 000010", {oa(), ia.din_ready, ia.busy});
        end
        nchk++;
        if ({ob(), ib.din_ready, ib.busy} !== 6'b000010) begin
            nerr++;
            $display("FAIL rst_mid_b: got %b want 000010", {ob(), ib.din_ready, ib.busy});
        end
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            ea = {w[4-k], 1'b1, k == 1, k == 4};
            eb = {w[k-1], 1'b1, k == 1, k == 4};
            nchk++;
            if (oa() !== ea) begin
                nerr++;
                $display("FAIL rst_restart_msb +%0d: got %b want %b", k, oa(), ea);
            end
            nchk++;
            if (ob() !== eb) begin
                nerr++;
                $display("FAIL rst_restart_lsb +%0d: got %b want %b", k, ob(), eb);
            end
        end
    endtask

    task automatic test_random();
        logic rdy;
        for (int i = 0; i < 400; i++) begin
            din = 4'($urandom);
            din_valid = $urandom_range(0, 3) != 0;
            rst = i == 0 || $urandom_range(0, 39) == 0;
            rdy = qa.size() == 0;
            if (i > 0) begin
                nchk++;
                if (ia.din_ready !== rdy || ib.din_ready !== rdy) begin
                    nerr++;
                    $display("FAIL rand_ready cycle %0d: got %b%b want %b", i, ia.din_ready, ib.din_ready, rdy);
                end
            end
            if (rst) begin
                qa.delete();
                qb.delete();
            end else if (din_valid && rdy) begin
                for (int j = 0; j < 4; j++) begin
                    qa.push_back({din[3-j], 1'b1, j == 0, j == 3});
                    qb.push_back({din[j], 1'b1, j == 0, j == 3});
                end
            end
            ea = qa.size() != 0 ? qa.pop_front() : 4'b0000;
            eb = qb.size() != 0 ? qb.pop_front() : 4'b0000;
            tick();
            nchk++;
            if (oa() !== ea || ia.busy !== ea[2]) begin
                nerr++;
                $display("FAIL rand_msb cycle %0d: got %b busy %b want %b", i, oa(), ia.busy, ea);
            end
            nchk++;
            if (ob() !== eb || ib.busy !== eb[2]) begin
                nerr++;
                $display("FAIL rand_lsb cycle %0d: got %b busy %b want %b", i, ob(), ib.busy, eb);
            end
        end
        rst = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
